// File: rtl/pusch_pp_pkg.sv
// Shared constants and state encoding for the mapper-to-FFT ping-pong write controller.
package pusch_pp_pkg;

    localparam int unsigned MEM_DEPTH        = 1200;
    localparam int unsigned DATA_WIDTH       = 18;
    localparam int unsigned ADDR_WIDTH       = 11;
    localparam int unsigned LAST_ADDR_OFFSET = 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        CHECK,
        WAIT_RD,
        CLOSE
    } state_e;

endpackage

// File: rtl/pingpong_wr_ctrl.sv
// Ping-pong bank write controller: fills one symbol block per bank, then hands it to the FFT reader.
// Latency: accepted sample appears on wr_en/wr_addr/wr_data one cycle later; all outputs registered.
// Backpressure: mod_ready only in FILL; held low while the reader drains (WAIT_RD). PINGPONG_ZERO_PAD_EN zero-fills flushed blocks.
import pusch_pp_pkg::*;

module pingpong_wr_ctrl #(
    parameter int unsigned MEM_DEPTH  = pusch_pp_pkg::MEM_DEPTH,
    parameter int unsigned DATA_WIDTH = pusch_pp_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = pusch_pp_pkg::ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic                  mod_valid,
    input  logic [DATA_WIDTH-1:0] mod_data,
    output logic                  mod_ready,
    input  logic                  flush,
    input  logic                  rd_busy,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  bank_sel,
    output logic                  bank_switch,
    output logic                  block_done,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  cfg_err,
    output logic                  ovf_err
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   count_q, count_d, len_q, wr_addr_q, last_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    wr_en_q, bank_sel_q, bank_switch_q, block_done_q;
    logic                    cfg_err_q, ovf_err_q, stop_q;
    logic                    accept, len_legal;

    assign mod_ready = (state_q == FILL);
    assign accept    = mod_valid & mod_ready;
    assign len_legal = (cfg_len != '0) && (cfg_len <= ADDR_WIDTH'(MEM_DEPTH));

    always_comb begin
        count_d = count_q;
        if (accept) count_d = count_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            count_q       <= '0;
            len_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            bank_sel_q    <= 1'b1;
            bank_switch_q <= 1'b0;
            block_done_q  <= 1'b0;
            last_addr_q   <= '0;
            cfg_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            bank_switch_q <= 1'b0;
            block_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            if (mod_valid && !mod_ready && state_q != IDLE) ovf_err_q <= 1'b1;
            if (cfg_stop && state_q != IDLE) stop_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if (len_legal) begin
                            len_q     <= cfg_len;
                            count_q   <= '0;
                            ovf_err_q <= 1'b0;
                            state_q   <= FILL;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count_d;
                        wr_data_q <= mod_data;
                        count_q   <= count_d;
                    end
                    // A sample accepted alongside flush is counted before the flush is judged.
                    if (accept && count_d == len_q) begin
                        state_q <= CHECK;
                    end else if (flush && count_d != '0) begin
`ifdef PINGPONG_ZERO_PAD_EN
                        state_q <= PAD;
`else
                        state_q <= CHECK;
`endif
                    end
                end
`ifdef PINGPONG_ZERO_PAD_EN
                PAD: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= count_q + ADDR_WIDTH'(1);
                    wr_data_q <= '0;
                    count_q   <= count_q + ADDR_WIDTH'(1);
                    if (count_q + ADDR_WIDTH'(1) == len_q) state_q <= CHECK;
                end
`endif
                CHECK, WAIT_RD: begin
                    if (rd_busy) begin
                        state_q <= WAIT_RD;
                    end else begin
                        block_done_q  <= 1'b1;
                        bank_switch_q <= 1'b1;
                        last_addr_q   <= count_q + ADDR_WIDTH'(LAST_ADDR_OFFSET);
                        bank_sel_q    <= ~bank_sel_q;
                        count_q       <= '0;
                        state_q       <= CLOSE;
                    end
                end
                CLOSE: begin
                    stop_q  <= 1'b0;
                    state_q <= (stop_q || cfg_stop) ? IDLE : FILL;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign bank_sel    = bank_sel_q;
    assign bank_switch = bank_switch_q;
    assign block_done  = block_done_q;
    assign last_addr   = last_addr_q;
    assign cfg_err     = cfg_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Directed table-driven bench for pingpong_wr_ctrl, plus a hand-written mid-block reset sequence.
module tb_pingpong_wr_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, flush = 1'b0, rd_busy = 1'b0, mod_valid = 1'b0;
    logic [10:0] cfg_len = '0;
    logic [17:0] mod_data = '0;
    logic        mod_ready, wr_en, bank_sel, bank_switch, block_done, cfg_err, ovf_err;
    logic [10:0] wr_addr, last_addr;
    logic [17:0] wr_data;

    pingpong_wr_ctrl dut (
        .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_len(cfg_len),
        .mod_valid(mod_valid), .mod_data(mod_data), .mod_ready(mod_ready), .flush(flush),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank_sel(bank_sel), .bank_switch(bank_switch), .block_done(block_done),
        .last_addr(last_addr), .cfg_err(cfg_err), .ovf_err(ovf_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        start, stop, flsh, valid, busy;
        logic [10:0] len;
        logic [17:0] data;
        logic [46:0] exp;
        logic [46:0] mask;
    } vec_t;

    vec_t        vq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        e_sel   = 1'b1;
    logic [10:0] e_last  = '0;
    logic        e_ovf   = 1'b0;

    function automatic logic [46:0] outs();
        return {mod_ready, wr_en, wr_addr, wr_data, bank_sel, bank_switch, block_done,
                last_addr, cfg_err, ovf_err};
    endfunction

    function automatic logic [46:0] mk(input logic rdy, input logic wen, input logic [10:0] addr,
                                        input logic [17:0] wd, input logic sel, input logic pulse,
                                        input logic [10:0] last, input logic cerr, input logic ovf);
        return {rdy, wen, addr, wd, sel, pulse, pulse, last, cerr, ovf};
    endfunction

    function automatic logic [46:0] mk_mask(input logic wen);
        logic [46:0] m;
        m = '1;
        if (!wen) m[44:16] = '0;
        return m;
    endfunction

    task automatic add(input logic start, input logic stop, input logic flsh, input logic valid,
                       input logic busy, input logic [10:0] len, input logic [17:0] data,
                       input logic rdy, input logic wen, input logic [10:0] addr,
                       input logic [17:0] wd, input logic pulse, input logic cerr);
        vec_t v;
        v.start = start; v.stop = stop; v.flsh = flsh; v.valid = valid; v.busy = busy;
        v.len   = len;   v.data = data;
        v.exp   = mk(rdy, wen, addr, wd, e_sel, pulse, e_last, cerr, e_ovf);
        v.mask  = mk_mask(wen);
        vq.push_back(v);
    endtask

    task automatic idle_row(input logic rdy, input logic pulse);
        add(0, 0, 0, 0, 0, 11'd0, 18'd0, rdy, 0, 11'd0, 18'd0, pulse, 0);
    endtask

    task automatic check(input string name, input int idx, input logic [46:0] act,
                         input logic [46:0] exp, input logic [46:0] mask);
        n_tests++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h (masked %h) expected %h", name, idx, act, act & mask, exp & mask);
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_init", 0, outs(), mk(0, 0, 11'd0, 18'd0, 1, 0, 11'd0, 0, 0), '1);
        RST = 1'b1;

        // Block 1: 12 samples, reader idle.
        add(1, 0, 0, 0, 0, 11'd12, 18'd0, 1, 0, 11'd0, 18'd0, 0, 0);
        for (int i = 1; i <= 12; i++)
            add(0, 0, 0, 1, 0, 11'd0, 18'(i), i < 12, 1, 11'(i), 18'(i), 0, 0);
        e_sel = 1'b0; e_last = 11'd13;
        idle_row(0, 1);
        idle_row(1, 0);

        // Block 2: reader busy for 5 cycles, stop requested.
        for (int i = 1; i <= 12; i++)
            add(0, 0, 0, 1, 0, 11'd0, 18'(100 + i), i < 12, 1, 11'(i), 18'(100 + i), 0, 0);
        add(0, 1, 0, 0, 1, 11'd0, 18'd0, 0, 0, 11'd0, 18'd0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 1, 11'd0, 18'd0, 0, 0, 11'd0, 18'd0, 0, 0);
        e_sel = 1'b1; e_last = 11'd13;
        idle_row(0, 1);
        idle_row(0, 0);

        // Illegal lengths.
        add(1, 0, 0, 0, 0, 11'd0, 18'd0, 0, 0, 11'd0, 18'd0, 0, 1);
        idle_row(0, 0);
        add(1, 0, 0, 0, 0, 11'd1201, 18'd0, 0, 0, 11'd0, 18'd0, 0, 1);
        idle_row(0, 0);

        // Flush after 10 of 24 samples, with stop.
        add(1, 0, 0, 0, 0, 11'd24, 18'd0, 1, 0, 11'd0, 18'd0, 0, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 0, 0, 1, 0, 11'd0, 18'(50 + i), 1, 1, 11'(i), 18'(50 + i), 0, 0);
        add(0, 1, 1, 0, 0, 11'd0, 18'd0, 0, 0, 11'd0, 18'd0, 0, 0);
`ifdef PINGPONG_ZERO_PAD_EN
        for (int a = 11; a <= 24; a++)
            add(0, 0, 0, 0, 0, 11'd0, 18'd0, 0, 1, 11'(a), 18'd0, 0, 0);
        e_sel = 1'b0; e_last = 11'd25;
`else
        e_sel = 1'b0; e_last = 11'd11;
`endif
        idle_row(0, 1);
        idle_row(0, 0);

        // Overflow while waiting on the reader; sticky until next legal start.
        add(1, 0, 0, 0, 0, 11'd2, 18'd0, 1, 0, 11'd0, 18'd0, 0, 0);
        add(0, 0, 0, 1, 0, 11'd0, 18'd7, 1, 1, 11'd1, 18'd7, 0, 0);
        add(0, 0, 0, 1, 0, 11'd0, 18'd8, 0, 1, 11'd2, 18'd8, 0, 0);
        e_ovf = 1'b1;
        add(0, 1, 0, 1, 1, 11'd0, 18'd9, 0, 0, 11'd0, 18'd0, 0, 0);
        add(0, 0, 0, 1, 1, 11'd0, 18'd9, 0, 0, 11'd0, 18'd0, 0, 0);
        e_sel = 1'b1; e_last = 11'd3;
        idle_row(0, 1);
        idle_row(0, 0);
        e_ovf = 1'b0;
        add(1, 0, 0, 0, 0, 11'd12, 18'd0, 1, 0, 11'd0, 18'd0, 0, 0);
        for (int i = 1; i <= 6; i++)
            add(0, 0, 0, 1, 0, 11'd0, 18'(200 + i), 1, 1, 11'(i), 18'(200 + i), 0, 0);

        foreach (vq[i]) begin
            cfg_start = vq[i].start; cfg_stop = vq[i].stop; flush = vq[i].flsh;
            mod_valid = vq[i].valid; rd_busy  = vq[i].busy; cfg_len = vq[i].len;
            mod_data  = vq[i].data;
            @(posedge CLK);
            #1;
            check("vec", i, outs(), vq[i].exp, vq[i].mask);
        end

        // Asynchronous reset in the middle of the block.
        RST = 1'b0;
        cfg_start = 0; cfg_stop = 0; flush = 0; mod_valid = 0; rd_busy = 0; cfg_len = '0; mod_data = '0;
        #1;
        check("reset_mid", 0, outs(), mk(0, 0, 11'd0, 18'd0, 1, 0, 11'd0, 0, 0), '1);
        @(posedge CLK);
        #1;
        check("reset_hold", 0, outs(), mk(0, 0, 11'd0, 18'd0, 1, 0, 11'd0, 0, 0), '1);
        RST = 1'b1;
        cfg_start = 1'b1; cfg_len = 11'd4;
        @(posedge CLK);
        #1;
        check("post_rst_start", 0, outs(), mk(1, 0, 11'd0, 18'd0, 1, 0, 11'd0, 0, 0), mk_mask(0));
        cfg_start = 1'b0; mod_valid = 1'b1; mod_data = 18'h33;
        @(posedge CLK);
        #1;
        check("post_rst_wr", 1, outs(), mk(1, 1, 11'd1, 18'h33, 1, 0, 11'd0, 0, 0), '1);
        mod_data = 18'h34;
        @(posedge CLK);
        #1;
        check("post_rst_wr", 2, outs(), mk(1, 1, 11'd2, 18'h34, 1, 0, 11'd0, 0, 0), '1);
        mod_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
